mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port RAM arbiter between icache and dcache (optional macro: ARB_FAIR_EN)
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ramready,
  output logic        ramerr
);

  localparam logic [31:0] BAD_LOAD = 32'hBAD0BAD0;
  localparam logic [7:0]  LAST_CNT = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_store;
  logic        r_dren;
  logic        r_dwen;
  logic        r_err;
  logic        w_dreq;
  logic        w_grant_d;
  logic        w_grant_i;
  logic        w_busy;
  logic        w_expired;
  logic        w_done;
  logic        w_timeout;
  logic [31:0] w_load;

  assign w_dreq = dREN | dWEN;

`ifdef ARB_FAIR_EN
  logic r_last_d;

  // On a tie, hand the RAM to whichever side did not get it last time.
  assign w_grant_d = w_dreq & (~iREN | ~r_last_d);

  // Remember which side won the most recent grant (reset favours data first).
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_last_d <= 1'b0;
    end else if (r_state == IDLE && (w_grant_d || w_grant_i)) begin
      r_last_d <= w_grant_d;
    end
  end
`else
  // On a tie, data always wins.
  assign w_grant_d = w_dreq;
`endif

  assign w_grant_i = iREN & ~w_grant_d;

  assign w_busy    = (r_state != IDLE);
  assign w_expired = (r_cnt == LAST_CNT);
  // ramready wins over the timeout when both land in the same cycle.
  assign w_done    = w_busy & (ramready | w_expired);
  assign w_timeout = w_busy & ~ramready & w_expired;
  assign w_load    = ramready ? ramload : BAD_LOAD;

  assign iload    = w_load;
  assign dload    = w_load;
  assign ramaddr  = r_addr;
  assign ramstore = r_store;
  assign ramerr   = r_err;

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and RAM strobe / wait generation.
  always_comb begin
    w_next = r_state;
    iwait  = 1'b1;
    dwait  = 1'b1;
    ramREN = 1'b0;
    ramWEN = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant_d) begin
          w_next = DACC;
        end else if (w_grant_i) begin
          w_next = IACC;
        end
      end
      IACC: begin
        ramREN = 1'b1;
        if (w_done) begin
          iwait  = 1'b0;
          w_next = IDLE;
        end
      end
      DACC: begin
        ramWEN = r_dwen;
        ramREN = r_dren & ~r_dwen;
        if (w_done) begin
          dwait  = 1'b0;
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Snapshot the winning request so a requester dropping mid-access cannot tear it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_addr  <= '0;
      r_store <= '0;
      r_dren  <= 1'b0;
      r_dwen  <= 1'b0;
    end else if (r_state == IDLE) begin
      if (w_grant_d) begin
        r_addr  <= daddr;
        r_store <= dstore;
        r_dren  <= dREN;
        r_dwen  <= dWEN;
      end else if (w_grant_i) begin
        r_addr  <= iaddr;
      end
    end
  end

  // Count cycles spent waiting on the RAM; cleared while idle and on completion.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt <= '0;
    end else if (r_state == IDLE || w_done) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  // Sticky error once any access is forced complete by the timeout.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_err <= 1'b0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter against a transaction model
module tb_mem_arbiter;

  localparam int TO = 8;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        iREN = 1'b0;
  logic [31:0] iaddr = '0;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN = 1'b0;
  logic        dWEN = 1'b0;
  logic [31:0] daddr = '0;
  logic [31:0] dstore = '0;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload = '0;
  logic        ramready = 1'b0;
  logic        ramerr;

  always #5 CLK = ~CLK;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramready(ramready), .ramerr(ramerr)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Transaction-level model: one outstanding access, identified by the cycle it was granted.
  bit          m_busy = 1'b0;
  bit          m_is_d = 1'b0;
  bit          m_we = 1'b0;
  bit          m_re = 1'b0;
  bit          m_err = 1'b0;
  logic [31:0] m_addr_out = '0;
  logic [31:0] m_store_out = '0;
  int          m_cyc = 0;
  int          m_start = 0;
`ifdef ARB_FAIR_EN
  bit          m_last_d = 1'b0;
`endif

  int n_ilow = 0;
  int n_dlow = 0;
  int n_ren_hi = 0;
  int n_wen_hi = 0;
  bit done_q[$];

  task automatic clear_tally();
    n_ilow = 0; n_dlow = 0; n_ren_hi = 0; n_wen_hi = 0;
    done_q.delete();
  endtask

  // Drive one cycle of inputs (called just after a falling edge), check, then advance the model.
  task automatic step(input bit ir, input logic [31:0] ia, input bit dr, input bit dw,
                      input logic [31:0] da, input logic [31:0] ds,
                      input bit rdy, input logic [31:0] rl);
    bit          done;
    bit          tmo;
    bit          pick_d;
    int          age;
    logic [31:0] eload;
    iREN = ir; iaddr = ia; dREN = dr; dWEN = dw; daddr = da; dstore = ds;
    ramready = rdy; ramload = rl;
    #1;
    age   = m_cyc - m_start;
    done  = m_busy && (rdy || age == TO);
    tmo   = done && !rdy;
    eload = rdy ? rl : 32'hBAD0BAD0;
    chk_eq("ramREN", ramREN, m_busy && (!m_is_d || (m_re && !m_we)));
    chk_eq("ramWEN", ramWEN, m_busy && m_is_d && m_we);
    chk_eq("ramaddr", ramaddr, m_addr_out);
    chk_eq("ramstore", ramstore, m_store_out);
    chk_eq("iwait", iwait, !(done && !m_is_d));
    chk_eq("dwait", dwait, !(done && m_is_d));
    if (done && !m_is_d) chk_eq("iload", iload, eload);
    if (done && m_is_d) chk_eq("dload", dload, eload);
    chk_eq("ramerr", ramerr, m_err);
    if (!iwait) begin n_ilow++; done_q.push_back(1'b0); end
    if (!dwait) begin n_dlow++; done_q.push_back(1'b1); end
    if (ramREN) n_ren_hi++;
    if (ramWEN) n_wen_hi++;
    @(negedge CLK);
    if (done) begin
      m_busy = 1'b0;
      if (tmo) m_err = 1'b1;
    end else if (!m_busy && (ir || dr || dw)) begin
`ifdef ARB_FAIR_EN
      pick_d   = (dr || dw) && (!ir || !m_last_d);
      m_last_d = pick_d;
`else
      pick_d = dr || dw;
`endif
      m_busy     = 1'b1;
      m_is_d     = pick_d;
      m_start    = m_cyc;
      m_re       = pick_d ? dr : 1'b1;
      m_we       = pick_d ? dw : 1'b0;
      m_addr_out = pick_d ? da : ia;
      if (pick_d) m_store_out = ds;
    end
    m_cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Assert reset between clock edges and confirm the outputs fall back at once.
  task automatic do_reset();
    #2;
    RST = 1'b1;
    #1;
    chk_eq("rst_ramREN", ramREN, 0);
    chk_eq("rst_ramWEN", ramWEN, 0);
    chk_eq("rst_ramaddr", ramaddr, 0);
    chk_eq("rst_ramstore", ramstore, 0);
    chk_eq("rst_iwait", iwait, 1);
    chk_eq("rst_dwait", dwait, 1);
    chk_eq("rst_ramerr", ramerr, 0);
    @(negedge CLK);
    RST = 1'b0;
    m_busy = 1'b0; m_err = 1'b0; m_addr_out = '0; m_store_out = '0;
`ifdef ARB_FAIR_EN
    m_last_d = 1'b0;
`endif
  endtask

  bit exp_seq[4];

  initial begin
`ifdef ARB_FAIR_EN
    exp_seq = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    @(negedge CLK);
    do_reset();

    // Instruction read, RAM ready on the third access cycle.
    clear_tally();
    step(1, 32'h40, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 32'h12345678);
    idle(2);
    chk_eq("i_read_ren_cycles", n_ren_hi, 3);
    chk_eq("i_read_completions", n_ilow, 1);

    // Data write, RAM ready immediately.
    clear_tally();
    step(0, 0, 0, 1, 32'h80, 32'hCAFEF00D, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 32'h0);
    idle(2);
    chk_eq("d_write_wen_cycles", n_wen_hi, 1);
    chk_eq("d_write_completions", n_dlow, 1);

    // Both sides held together with an always-ready RAM.
    do_reset();
    clear_tally();
    for (int k = 0; k < 8; k++) step(1, 32'h100 + k, 1, 0, 32'h200 + k, 0, 1, 32'h5A5A0000 + k);
    idle(1);
    chk_eq("tie_completions", done_q.size(), 4);
    for (int k = 0; k < 4 && k < done_q.size(); k++) chk_eq($sformatf("tie_side_%0d", k), done_q[k], exp_seq[k]);

    // ramready arriving exactly on the timeout cycle is a normal completion.
    step(0, 0, 1, 0, 32'h300, 0, 0, 0);
    for (int k = 0; k < TO - 1; k++) step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 32'h0BADCAFE);
    idle(1);
    chk_eq("ready_at_timeout_err", ramerr, 0);

    // RAM never answers: forced completion on the last allowed cycle, sticky error.
    clear_tally();
    step(0, 0, 1, 0, 32'h304, 0, 0, 0);
    for (int k = 0; k < TO; k++) step(0, 0, 0, 0, 0, 0, 0, 0);
    idle(3);
    chk_eq("timeout_completions", n_dlow, 1);
    chk_eq("timeout_err_sticky", ramerr, 1);
    do_reset();

    // Reset in the middle of a data write, then a normal request.
    clear_tally();
    step(0, 0, 0, 1, 32'h400, 32'h11112222, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();
    chk_eq("rst_abandon_completions", n_dlow, 0);
    step(1, 32'h404, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 32'h33334444);
    idle(1);
    chk_eq("post_rst_served", n_ilow, 1);

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 2) == 0, $urandom, $urandom_range(0, 2) == 0,
             $urandom_range(0, 3) == 0, $urandom, $urandom,
             $urandom_range(0, 9) < 4, $urandom);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
